// File: rtl/uart_tx_arb.sv
// Two-requester arbiter that feeds one byte at a time into a uart_tx.
// Define UART_TX_ARB_FIXED_PRIO_EN to select fixed priority (req0 wins ties).
// Leave it undefined to select round-robin arbitration.
module uart_tx_arb #(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned BAUD     = 9_600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ack,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ack,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       grant_id,
  output logic       arb_busy
);

  typedef enum logic [1:0] {StIdle, StStart, StWaitBusy, StWaitDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] buf_q, buf_d;
  logic       grant_q, grant_d;
  logic       any_req;
  logic       pick1;

  assign any_req = req0_valid | req1_valid;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  assign pick1 = ~req0_valid;
`else
  // Requester granted most recently; resets to 1 so requester 0 wins the first tie.
  logic last_q;

  assign pick1 = req1_valid & (~req0_valid | ~last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (req0_ack | req1_ack) begin
      last_q <= pick1;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    grant_d  = grant_q;
    req0_ack = 1'b0;
    req1_ack = 1'b0;
    tx_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Acks are gated by rst so a transfer abandoned by reset is never acknowledged.
        if (!rst && !tx_busy && any_req) begin
          buf_d    = pick1 ? req1_data : req0_data;
          grant_d  = pick1;
          req0_ack = ~pick1;
          req1_ack = pick1;
          state_d  = StStart;
        end
      end
      StStart: begin
        tx_start = ~rst;
        state_d  = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!tx_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      buf_q   <= 8'h00;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      grant_q <= grant_d;
    end
  end

  assign tx_data  = buf_q;
  assign grant_id = grant_q;
  assign arb_busy = (state_q != StIdle);

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter CLK_FREQ, default 12_000_000, system clock frequency in Hz, passed through for documentation and bench timing only.
REQ-002 Parameter BAUD, default 9_600, line rate of the attached uart_tx, passed through for documentation and bench timing only.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 has a byte to send; held until accepted.
REQ-006 req0_data  input  8  requester 0 byte; stable while req0_valid high.
REQ-007 req0_ack  output  1  one-cycle pulse: requester 0 byte accepted.
REQ-008 req1_valid  input  1  requester 1 has a byte to send; held until accepted.
REQ-009 req1_data  input  8  requester 1 byte; stable while req1_valid high.
REQ-010 req1_ack  output  1  one-cycle pulse: requester 1 byte accepted.
REQ-011 tx_start  output  1  start pulse to uart_tx.
REQ-012 tx_data  output  8  byte to uart_tx; valid while tx_start high.
REQ-013 tx_busy  input  1  busy flag from uart_tx.
REQ-014 grant_id  output  1  requester owning the current or most recent transfer.
REQ-015 arb_busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: if tx_busy=0 and any reqN_valid=1, select a winner, latch its data into an internal 8-bit buffer, pulse that requester's ack for exactly this cycle, set grant_id, and go to START.
REQ-018 IDLE with tx_busy=1: no grant and no ack; remain in IDLE regardless of requests.
REQ-019 START: tx_start=1 and tx_data=buffer for exactly one cycle; then go to WAIT_BUSY.
REQ-020 WAIT_BUSY: tx_start=0; on tx_busy=1 go to WAIT_DONE, otherwise remain.
REQ-021 WAIT_DONE: on tx_busy=0 go to IDLE, otherwise remain.
REQ-022 Round-robin tie-break: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-023 The last-granted pointer updates only on a grant.
REQ-024 At most one ack is high per cycle.
REQ-025 Acks never occur outside IDLE.
REQ-026 Minimum spacing between two grants is 4 cycles: IDLE, START, WAIT_BUSY ≥1, WAIT_DONE ≥1.
REQ-027 reqN_valid dropping without ack is legal; no ack is issued for the withdrawn request.
REQ-028 tx_data holds the buffer value in every state; only tx_start qualifies it.

Reset
REQ-029 While rst=1 on a clock edge: state becomes IDLE, tx_start=0, req0_ack=0, req1_ack=0, grant_id=0, arb_busy=0, buffer=0x00, and the last-granted pointer becomes 1 so requester 0 wins the first tie.
REQ-030 A reset in START, WAIT_BUSY or WAIT_DONE abandons the transfer; no ack is reissued.
REQ-031 After reset, the first grant waits for tx_busy=0.

Configuration
REQ-032 Macro UART_TX_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins a tie; the last-granted pointer is not implemented.
REQ-033 Macro UART_TX_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-022.

Verification
REQ-034 Reset, then req0_valid=1 with req0_data=0x41 and tx_busy=0 -> req0_ack pulses in the same cycle; tx_start=1 with tx_data=0x41 in the next cycle; grant_id=0.
REQ-035 req0 (0x10) and req1 (0x20) held valid continuously, uart_tx model busy 10 cycles after each start, round-robin build -> bytes sent in order 0x10, 0x20, 0x10, 0x20; fixed-priority build -> 0x10 repeated.
REQ-036 tx_busy held 1 while req1_valid=1 -> no ack and arb_busy=0; tx_busy falls -> req1_ack pulses that cycle.
REQ-037 Model delays tx_busy rise by 3 cycles after tx_start -> FSM stays in WAIT_BUSY 3 cycles, exactly one tx_start pulse, then completes normally.
REQ-038 rst=1 asserted in WAIT_DONE -> next cycle arb_busy=0 and tx_start=0; with both requesters then valid, requester 0 is granted first.
REQ-039 Assertions for the whole run: acks mutually exclusive; tx_start never high two consecutive cycles; one ack per tx_start.
